merge_arb: RTL and testbench

Round-robin, transaction-locking arbiter that shares one native-bus slave port among N_MASTERS native-bus masters. It grants one master at a time, registers that master's request onto the slave port, holds the grant until the slave returns `ready` or a timeout fires, then re-arbitrates. It sits in front of the interconnect merge stage, replacing fixed-priority selection where fairness and bounded latency are required.

---
 rtl/merge_arb_pkg.sv | 25 ++
 rtl/merge_rr_sel.sv | 33 +++
 rtl/merge_arb.sv | 128 ++++++++++++
 tb/tb_merge_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_arb_pkg.sv
// Shared definitions for the merge arbiter: FSM state encoding and
// derived bus-field widths used by the arbiter and its neighbours.
package merge_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Request bundle carried to the slave: {addr, wdata, wstrb}.
  function automatic int req_w(input int addr_w, input int data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

  // Response bundle returned to a master: {rdata, ready}.
  function automatic int rsp_w(input int data_w);
    return data_w + 1;
  endfunction

  // Wait-counter width; a disabled timeout still needs one bit.
  function automatic int cnt_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/merge_rr_sel.sv
// Round-robin selector: picks the first valid requester after the last
// granted index, wrapping modulo N_MASTERS.
module merge_rr_sel
  import merge_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int IDX_W     = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] valid_i,
  input  logic [IDX_W-1:0]     last_i,
  output logic                 any_o,
  output logic [IDX_W-1:0]     sel_o
);

  always_comb begin
    int              idx;
    logic [IDX_W-1:0] cand;
    idx   = 0;
    cand  = '0;
    any_o = 1'b0;
    sel_o = '0;
    // Offset 1 first so the previous owner is considered last.
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx  = (int'(last_i) + k) % N_MASTERS;
      cand = IDX_W'(idx);
      if (!any_o && valid_i[cand]) begin
        any_o = 1'b1;
        sel_o = cand;
      end
    end
  end

endmodule

// File: rtl/merge_arb.sv
// Round-robin, transaction-locking arbiter sharing one native-bus slave
// among N_MASTERS masters, with an optional slave-wait timeout.
module merge_arb
  import merge_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ready,
  output logic [N_MASTERS-1:0]            grant,
  output logic                            timeout_err
);

  localparam int IDX_W  = $clog2(N_MASTERS);
  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = req_w(ADDR_W, DATA_W);
  localparam int CNT_W  = cnt_w(TIMEOUT);
  // Counter is cleared on the grant edge, so the Nth BUSY cycle sees N-1.
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_MASTERS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [REQ_W-1:0]     req_q, req_d;
  logic                 s_valid_q, s_valid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 any_vld;
  logic [IDX_W-1:0]     sel_idx;
  logic [REQ_W-1:0]     sel_req;
  logic                 busy;
  logic                 timeout_hit;
  logic                 done;

  merge_rr_sel #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_rr_sel (
    .valid_i (m_valid),
    .last_i  (last_q),
    .any_o   (any_vld),
    .sel_o   (sel_idx)
  );

  always_comb begin
    sel_req = {m_addr[int'(sel_idx)*ADDR_W +: ADDR_W],
               m_wdata[int'(sel_idx)*DATA_W +: DATA_W],
               m_wstrb[int'(sel_idx)*STRB_W +: STRB_W]};
  end

  // Response steering: only the owner ever sees ready.
  assign busy        = (state_q == ST_BUSY);
  assign timeout_hit = (TIMEOUT != 0) && busy && (cnt_q >= TO_LAST);
  assign done        = busy && (s_ready || timeout_hit);
  assign m_ready     = done ? grant_q : '0;
  assign m_rdata     = (busy && s_ready) ? s_rdata : '0;
  assign timeout_err = timeout_hit && !s_ready;

  assign s_valid                   = s_valid_q;
  assign {s_addr, s_wdata, s_wstrb} = req_q;
  assign grant                     = grant_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    req_d     = req_q;
    s_valid_d = s_valid_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_vld) begin
          state_d          = ST_BUSY;
          s_valid_d        = 1'b1;
          req_d            = sel_req;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          last_d           = sel_idx;
          cnt_d            = '0;
        end
      end
      ST_BUSY: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (done) begin
          state_d   = ST_IDLE;
          s_valid_d = 1'b0;
          grant_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= LAST_RST;
      grant_q   <= '0;
      req_q     <= '0;
      s_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      req_q     <= req_d;
      s_valid_q <= s_valid_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_merge_arb.sv
// Self-checking bench for merge_arb (4 masters, timeout of 8 cycles).
module tb_merge_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      m_valid;
  logic [N*AW-1:0]   m_addr;
  logic [N*DW-1:0]   m_wdata;
  logic [N*SW-1:0]   m_wstrb;
  logic [DW-1:0]     m_rdata;
  logic [N-1:0]      m_ready;
  logic              s_valid;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [SW-1:0]     s_wstrb;
  logic [DW-1:0]     s_rdata;
  logic              s_ready;
  logic [N-1:0]      grant;
  logic              timeout_err;

  always #5 clk = ~clk;

  merge_arb #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_valid     (m_valid),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_rdata     (m_rdata),
    .m_ready     (m_ready),
    .s_valid     (s_valid),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_rdata     (s_rdata),
    .s_ready     (s_ready),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    bit          rdy;
    logic [31:0] rdata;
    bit          chg;
  } vec_t;

  typedef struct {
    logic [N-1:0] ready;
    logic [31:0]  rdata;
    logic         terr;
  } exp_t;

  vec_t tbl[7];
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic set_master(input int m, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    m_addr[m*AW +: AW]  = a;
    m_wdata[m*DW +: DW] = d;
    m_wstrb[m*SW +: SW] = s;
  endtask

  task automatic wait_svalid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!s_valid && n < 8);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_m_ready"}, 32'(m_ready), 32'(e.ready));
      chk({tag, "_m_rdata"}, m_rdata, e.rdata);
      chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(e.terr));
    end
  endtask

  task automatic do_txn(input vec_t v);
    exp_t e;
    int   n;
    @(negedge clk);
    set_master(v.m, v.addr, v.wdata, v.wstrb);
    m_valid[v.m] = 1'b1;
    s_ready      = 1'b0;
    s_rdata      = v.rdata;
    e.ready      = 4'b0001 << v.m;
    e.rdata      = v.rdy ? v.rdata : 32'h0;
    e.terr       = !v.rdy;
    sbq.push_back(e);
    #1;
    chk("idle_grant", 32'(grant), 32'h0);
    wait_svalid(n);
    chk("req_latency", n, 32'd1);
    chk("grant", 32'(grant), 32'(4'b0001 << v.m));
    chk("s_addr", s_addr, v.addr);
    chk("s_wdata", s_wdata, v.wdata);
    chk("s_wstrb", 32'(s_wstrb), 32'(v.wstrb));
    if (v.chg) set_master(v.m, ~v.addr, ~v.wdata, ~v.wstrb);
    for (int i = 0; i < v.lat; i++) begin
      chk("busy_m_ready", 32'(m_ready), 32'h0);
      chk("busy_timeout_err", 32'(timeout_err), 32'h0);
      @(negedge clk);
      #1;
    end
    if (v.rdy) s_ready = 1'b1;
    #1;
    pop_cmp("done");
    chk("held_s_addr", s_addr, v.addr);
    chk("held_s_wdata", s_wdata, v.wdata);
    @(negedge clk);
    s_ready      = 1'b0;
    m_valid[v.m] = 1'b0;
    #1;
    chk("after_s_valid", 32'(s_valid), 32'h0);
    chk("after_grant", 32'(grant), 32'h0);
    chk("after_m_ready", 32'(m_ready), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int   n;
    int   last;
    int   served[N];
    exp_t e;

    tbl[0] = '{2, 32'h0000_0100, 32'hA5A5_0001, 4'hF, 3, 1'b1, 32'h0000_0000, 1'b0};
    tbl[1] = '{1, 32'h0000_0200, 32'h0000_0000, 4'h0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    tbl[2] = '{3, 32'hFFFF_FFFC, 32'h1122_3344, 4'h5, 1, 1'b1, 32'h1234_5678, 1'b0};
    tbl[3] = '{0, 32'h0000_0400, 32'h0000_0000, 4'h0, 7, 1'b0, 32'hCAFE_F00D, 1'b0};
    tbl[4] = '{2, 32'h0000_0500, 32'h55AA_55AA, 4'h3, 7, 1'b1, 32'h0BAD_F00D, 1'b0};
    tbl[5] = '{1, 32'h0000_0600, 32'h7777_7777, 4'hC, 2, 1'b1, 32'h0000_0000, 1'b1};
    tbl[6] = '{3, 32'h0000_0700, 32'h0000_0000, 4'h0, 7, 1'b0, 32'h1357_9BDF, 1'b0};

    rst_n   = 1'b0;
    m_valid = '1;
    m_addr  = '1;
    m_wdata = '1;
    m_wstrb = '1;
    s_ready = 1'b1;
    s_rdata = 32'hFFFF_FFFF;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_s_valid", 32'(s_valid), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_m_ready", 32'(m_ready), 32'h0);
    chk("rst_m_rdata", m_rdata, 32'h0);
    chk("rst_timeout_err", 32'(timeout_err), 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_s_wstrb", 32'(s_wstrb), 32'h0);

    @(negedge clk);
    m_valid = '0;
    s_ready = 1'b0;
    rst_n   = 1'b1;

    foreach (tbl[i]) do_txn(tbl[i]);

    // s_ready while idle must not reach any master.
    @(negedge clk);
    s_ready = 1'b1;
    s_rdata = 32'hA0A0_A0A0;
    #1;
    chk("idle_s_ready_m_ready", 32'(m_ready), 32'h0);
    chk("idle_s_ready_m_rdata", m_rdata, 32'h0);
    @(negedge clk);
    s_ready = 1'b0;
    #1;
    chk("idle_s_ready_grant", 32'(grant), 32'h0);

    // All masters contend continuously; last owner was master 3.
    last = 3;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      set_master(i, 32'h1000 + 32'(i), 32'h0, 4'h0);
      served[i] = 0;
    end
    m_valid = '1;
    s_rdata = 32'h0;
    for (int t = 0; t < 2 * N; t++) begin
      e.ready = 4'b0001 << ((last + 1 + t) % N);
      e.rdata = 32'h0;
      e.terr  = 1'b0;
      sbq.push_back(e);
    end
    for (int t = 0; t < 2 * N; t++) begin
      wait_svalid(n);
      chk("rr_latency", n, 32'd1);
      chk("rr_grant", 32'(grant), 32'(4'b0001 << ((last + 1 + t) % N)));
      chk("rr_s_addr", s_addr, 32'h1000 + 32'((last + 1 + t) % N));
      for (int i = 0; i < N; i++) if (grant[i]) served[i]++;
      s_ready = 1'b1;
      #1;
      pop_cmp("rr");
      @(negedge clk);
      s_ready = 1'b0;
      if (t == 2 * N - 1) m_valid = '0;
      #1;
      chk("rr_idle_s_valid", 32'(s_valid), 32'h0);
    end
    for (int i = 0; i < N; i++) chk("rr_served_count", served[i], 32'd2);

    // Reset while busy: abandons transaction, restores master-0 priority.
    @(negedge clk);
    set_master(1, 32'h0000_0300, 32'h0, 4'h0);
    m_valid[1] = 1'b1;
    wait_svalid(n);
    chk("mid_rst_grant_before", 32'(grant), 32'h2);
    @(negedge clk);
    #1;
    @(negedge clk);
    rst_n   = 1'b0;
    s_ready = 1'b1;
    m_valid = 4'b1001;
    set_master(0, 32'h0000_0A00, 32'h0, 4'h0);
    set_master(3, 32'h0000_0D00, 32'h0, 4'h0);
    #1;
    chk("mid_rst_s_valid", 32'(s_valid), 32'h0);
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_m_ready", 32'(m_ready), 32'h0);
    chk("mid_rst_s_addr", s_addr, 32'h0);
    @(negedge clk);
    s_ready = 1'b0;
    rst_n   = 1'b1;
    #1;
    chk("post_rst_idle_grant", 32'(grant), 32'h0);
    e.ready = 4'b0001;
    e.rdata = 32'h0;
    e.terr  = 1'b0;
    sbq.push_back(e);
    wait_svalid(n);
    chk("post_rst_latency", n, 32'd1);
    chk("post_rst_grant", 32'(grant), 32'h1);
    chk("post_rst_s_addr", s_addr, 32'h0000_0A00);
    s_ready = 1'b1;
    s_rdata = 32'h0;
    #1;
    pop_cmp("post_rst");
    @(negedge clk);
    s_ready = 1'b0;
    m_valid = '0;
    #1;
    chk("post_rst_final_grant", 32'(grant), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
